regbank_dump_arbiter: RTL and testbench

REGBANK_DUMP_ARBITER -- requirements
Module: regbank_dump_arbiter

---
 rtl/regbank_dump_arbiter_pkg.sv | 17 +
 rtl/regbank_dump_arbiter_banco.sv | 31 +++
 rtl/regbank_dump_arbiter.sv | 129 ++++++++++++
 tb/tb_regbank_dump_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_dump_arbiter_pkg.sv
// Shared sizing constants and dump FSM state encoding for the register-bank dump arbiter.
// No logic; imported by the arbiter top and the bank.
package regbank_dump_arbiter_pkg;

    localparam int RB_NUM_REGS = 32;
    localparam int RB_DATA_W   = 32;
    localparam int RB_IDX_W    = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_READ    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/regbank_dump_arbiter_banco.sv
// Register bank: one write port, two asynchronous read ports, no reset on contents.
// Write lands at the rising edge; a same-cycle read returns the old value.
module regbank_dump_arbiter_banco
    import regbank_dump_arbiter_pkg::*;
#(
    parameter int NUM_REGS = RB_NUM_REGS,
    parameter int DATA_W   = RB_DATA_W,
    parameter int IDX_W    = RB_IDX_W
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wreg,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_rreg1,
    input  logic [IDX_W-1:0]  i_rreg2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_regs[i_wreg] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_rreg1];
    assign o_rdata2 = r_regs[i_rreg2];

endmodule

// File: rtl/regbank_dump_arbiter.sv
// Register bank with pipeline/debug write arbitration and a stalled, handshaked dump stream.
// First dump beat 3 cycles after dumpStart; each beat holds until dumpValid & dumpReady.
module regbank_dump_arbiter
    import regbank_dump_arbiter_pkg::*;
#(
    parameter int NUM_REGS = RB_NUM_REGS,
    parameter int DATA_W   = RB_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pRegWrite,
    input  logic [RB_IDX_W-1:0] pWriteReg,
    input  logic [DATA_W-1:0]   pWriteData,
    input  logic [RB_IDX_W-1:0] pReadReg1,
    input  logic [RB_IDX_W-1:0] pReadReg2,
    output logic [DATA_W-1:0]   pReadData1,
    output logic [DATA_W-1:0]   pReadData2,
    input  logic                dbgWrite,
    input  logic [RB_IDX_W-1:0] dbgWriteReg,
    input  logic [DATA_W-1:0]   dbgWriteData,
    output logic                dbgWriteAck,
    input  logic                dumpStart,
    input  logic                dumpReady,
    output logic                dumpValid,
    output logic [RB_IDX_W-1:0] dumpAddr,
    output logic [DATA_W-1:0]   dumpData,
    output logic                dumpDone,
    output logic                stall
);

    localparam logic [RB_IDX_W-1:0] LAST_IDX = RB_IDX_W'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [RB_IDX_W-1:0] r_index;
    logic [RB_IDX_W-1:0] w_index_nxt;
    logic [RB_IDX_W-1:0] r_dump_addr;
    logic [DATA_W-1:0]   r_dump_data;

    logic                w_bank_we;
    logic [RB_IDX_W-1:0] w_bank_wreg;
    logic [DATA_W-1:0]   w_bank_wdata;
    logic                w_dump_phase;
    logic [RB_IDX_W-1:0] w_rd_reg1;
    logic [DATA_W-1:0]   w_rd_data1;

    // Pipeline owns the write port; debug only gets the idle slots.
    assign dbgWriteAck  = reset & dbgWrite & ~pRegWrite;
    assign w_bank_we    = reset & (pRegWrite | dbgWrite);
    assign w_bank_wreg  = pRegWrite ? pWriteReg  : dbgWriteReg;
    assign w_bank_wdata = pRegWrite ? pWriteData : dbgWriteData;

    assign w_dump_phase = (r_state == S_READ) || (r_state == S_PRESENT);
    assign w_rd_reg1    = w_dump_phase ? r_index : pReadReg1;
    assign pReadData1   = w_rd_data1;

    regbank_dump_arbiter_banco #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (RB_IDX_W)
    ) REGBANK_banco (
        .i_clk    (clock),
        .i_we     (w_bank_we),
        .i_wreg   (w_bank_wreg),
        .i_wdata  (w_bank_wdata),
        .i_rreg1  (w_rd_reg1),
        .i_rreg2  (pReadReg2),
        .o_rdata1 (w_rd_data1),
        .o_rdata2 (pReadData2)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        case (r_state)
            S_IDLE: begin
                if (dumpStart) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_READ;
                w_index_nxt = '0;
            end
            S_READ: begin
                w_state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                if (dumpReady) begin
                    if (r_index == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_index_nxt = r_index + 1'b1;
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_dump_addr <= '0;
            r_dump_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            if (r_state == S_READ) begin
                r_dump_addr <= r_index;
                r_dump_data <= w_rd_data1;
            end
        end
    end

    assign dumpValid = (r_state == S_PRESENT);
    assign dumpDone  = (r_state == S_DONE);
    assign stall     = (r_state == S_DRAIN) || w_dump_phase;
    assign dumpAddr  = r_dump_addr;
    assign dumpData  = r_dump_data;

endmodule

// File: tb/tb_regbank_dump_arbiter.sv
// Randomized scoreboard bench for regbank_dump_arbiter against an array model of the bank.
module tb_regbank_dump_arbiter;

    localparam int NR = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          pRegWrite = 1'b0;
    logic [4:0]    pWriteReg = '0;
    logic [DW-1:0] pWriteData = '0;
    logic [4:0]    pReadReg1 = '0;
    logic [4:0]    pReadReg2 = '0;
    logic [DW-1:0] pReadData1;
    logic [DW-1:0] pReadData2;
    logic          dbgWrite = 1'b0;
    logic [4:0]    dbgWriteReg = '0;
    logic [DW-1:0] dbgWriteData = '0;
    logic          dbgWriteAck;
    logic          dumpStart = 1'b0;
    logic          dumpReady = 1'b0;
    logic          dumpValid;
    logic [4:0]    dumpAddr;
    logic [DW-1:0] dumpData;
    logic          dumpDone;
    logic          stall;

    regbank_dump_arbiter #(.NUM_REGS(NR), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .pRegWrite(pRegWrite), .pWriteReg(pWriteReg), .pWriteData(pWriteData),
        .pReadReg1(pReadReg1), .pReadReg2(pReadReg2),
        .pReadData1(pReadData1), .pReadData2(pReadData2),
        .dbgWrite(dbgWrite), .dbgWriteReg(dbgWriteReg), .dbgWriteData(dbgWriteData),
        .dbgWriteAck(dbgWriteAck),
        .dumpStart(dumpStart), .dumpReady(dumpReady), .dumpValid(dumpValid),
        .dumpAddr(dumpAddr), .dumpData(dumpData), .dumpDone(dumpDone), .stall(stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            done;
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            beat_cnt = 0;
    int            done_cnt = 0;
    logic [DW-1:0] model [NR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock edge; the model takes the write the bank should take on that edge.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            if (pRegWrite)     model[pWriteReg]   = pWriteData;
            else if (dbgWrite) model[dbgWriteReg] = dbgWriteData;
        end
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        pRegWrite = 1'b0;
        dbgWrite  = 1'b0;
        dumpStart = 1'b0;
    endtask

    task automatic do_dump(input int rdy_pct, input int hold_at, input bit start_pulse,
                           input int abort_at, input bit drain_wr);
        int b0;
        int d0;
        int cyc;
        int done_off;
        int hold_cnt;
        bit held;
        bit pulsed;
        bit finished;
        b0 = beat_cnt; d0 = done_cnt; cyc = 0; done_off = -1;
        hold_cnt = 0; held = 0; pulsed = 0; finished = 0;
        idle();
        dumpReady = 1'b0;
        dumpStart = 1'b1;
        settle();
        chk("idle_stall", 32'(stall), 32'd0);
        tick();
        dumpStart = 1'b0;
        if (drain_wr) begin
            pRegWrite = 1'b1; pWriteReg = 5'd3; pWriteData = 32'h0000FFFF;
        end
        settle();
        chk("drain_stall", 32'(stall), 32'd1);
        chk("drain_valid", 32'(dumpValid), 32'd0);
        tick();
        idle();
        for (int k = 0; k < NR; k++) sb_q.push_back('{done: 1'b0, addr: 5'(k), data: model[k]});
        if (abort_at < 0) sb_q.push_back('{done: 1'b1, addr: 5'd0, data: '0});
        while (!finished && cyc < 600) begin
            #1;
            dumpStart = 1'b0;
            pReadReg2 = 5'($urandom);
            dumpReady = ($urandom_range(1, 100) <= rdy_pct);
            if (dumpValid && hold_at >= 0 && dumpAddr == 5'(hold_at) && !held) begin
                held = 1; hold_cnt = 3;
            end
            if (hold_cnt > 0) begin
                dumpReady = 1'b0;
                hold_cnt--;
                chk("hold_addr", 32'(dumpAddr), 32'(hold_at));
            end
            if (start_pulse && dumpValid && dumpAddr == 5'd4 && !pulsed) begin
                dumpStart = 1'b1; pulsed = 1;
            end
            if (abort_at >= 0 && dumpValid && dumpAddr == 5'(abort_at)) begin
                reset = 1'b0; dumpReady = 1'b0;
                tick();
                reset = 1'b1;
                sb_q.delete();
                settle();
                chk("abort_stall", 32'(stall), 32'd0);
                chk("abort_valid", 32'(dumpValid), 32'd0);
                chk("abort_done", 32'(dumpDone), 32'd0);
                for (int j = 0; j < 4; j++) begin
                    tick();
                    settle();
                    chk("abort_quiet", 32'({stall, dumpValid, dumpDone}), 32'd0);
                end
                finished = 1;
            end else begin
                #1;
                if (cyc == 0) chk("first_read_no_valid", 32'(dumpValid), 32'd0);
                if (cyc == 1) chk("first_valid_latency", 32'(dumpValid), 32'd1);
                chk("dump_rd2", pReadData2, model[pReadReg2]);
                if (dumpDone) begin
                    done_off = cyc; finished = 1;
                end else begin
                    chk("dump_stall", 32'(stall), 32'd1);
                end
                tick();
                cyc++;
            end
        end
        dumpReady = 1'b0;
        dumpStart = 1'b0;
        if (!finished) begin
            miscompares++; vectors++;
            $display("FAIL dump_timeout: no dumpDone within %0d cycles, required completion", cyc);
        end else if (abort_at < 0) begin
            settle();
            chk("done_one_cycle", 32'(dumpDone), 32'd0);
            chk("post_done_stall", 32'(stall), 32'd0);
            chk("beats", 32'(beat_cnt - b0), 32'(NR));
            chk("dones", 32'(done_cnt - d0), 32'd1);
            if (rdy_pct == 100 && hold_at < 0) chk("done_cycle", 32'(done_off), 32'(2 * NR));
            tick();
        end
    endtask

    // Scoreboard monitor: every handshake and every dumpDone pops the next expected item.
    initial begin : monitor
        exp_t          e;
        logic          pv = 0, pr = 0, prst = 0, phs_last = 0;
        logic [4:0]    pa = '0;
        logic [DW-1:0] pd = '0;
        forever begin
            @(negedge clock);
            if (pv && !pr && prst) begin
                chk("hold_valid", 32'(dumpValid), 32'd1);
                chk("hold_addr_stable", 32'(dumpAddr), 32'(pa));
                chk("hold_data_stable", dumpData, pd);
            end
            if (dumpValid && dumpReady) begin
                beat_cnt++;
                chk("beat_stall", 32'(stall), 32'd1);
                chk("beat_expected", 32'(sb_q.size() > 0 && !sb_q[0].done), 32'd1);
                if (sb_q.size() > 0 && !sb_q[0].done) begin
                    e = sb_q.pop_front();
                    chk("beat_addr", 32'(dumpAddr), 32'(e.addr));
                    chk("beat_data", dumpData, e.data);
                end
            end
            if (dumpDone) begin
                done_cnt++;
                chk("done_after_last_beat", 32'(phs_last), 32'd1);
                chk("done_stall", 32'(stall), 32'd0);
                chk("done_expected", 32'(sb_q.size() > 0 && sb_q[0].done), 32'd1);
                if (sb_q.size() > 0 && sb_q[0].done) e = sb_q.pop_front();
            end
            phs_last = dumpValid && dumpReady && (dumpAddr == 5'(NR - 1));
            pv = dumpValid; pr = dumpReady; prst = reset; pa = dumpAddr; pd = dumpData;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin : stim
        // Reset, with a debug request that must not be acknowledged.
        reset = 1'b0; dbgWrite = 1'b1; dbgWriteReg = 5'd4; dbgWriteData = 32'h11111111;
        tick(); tick();
        settle();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_valid", 32'(dumpValid), 32'd0);
        chk("rst_done", 32'(dumpDone), 32'd0);
        chk("rst_addr", 32'(dumpAddr), 32'd0);
        chk("rst_data", dumpData, 32'd0);
        chk("rst_dbg_ack", 32'(dbgWriteAck), 32'd0);
        reset = 1'b1;
        idle();

        for (int i = 0; i < NR; i++) begin
            pRegWrite = 1'b1; pWriteReg = 5'(i); pWriteData = $urandom;
            tick();
        end
        idle();

        for (int i = 0; i < 150; i++) begin
            pRegWrite = 1'($urandom_range(0, 1)); pWriteReg = 5'($urandom); pWriteData = $urandom;
            dbgWrite = 1'($urandom_range(0, 1)); dbgWriteReg = 5'($urandom); dbgWriteData = $urandom;
            pReadReg1 = 5'($urandom); pReadReg2 = 5'($urandom);
            settle();
            chk("dbg_ack", 32'(dbgWriteAck), 32'(dbgWrite && !pRegWrite));
            chk("rd1", pReadData1, model[pReadReg1]);
            chk("rd2", pReadData2, model[pReadReg2]);
            tick();
        end
        idle();

        // Pipeline and debug collide, then debug gets the next free slot.
        pRegWrite = 1'b1; pWriteReg = 5'd5; pWriteData = 32'h12345678;
        dbgWrite = 1'b1; dbgWriteReg = 5'd6; dbgWriteData = 32'hDEADBEEF;
        settle();
        chk("collide_ack", 32'(dbgWriteAck), 32'd0);
        tick();
        pRegWrite = 1'b0;
        settle();
        chk("dbg_slot_ack", 32'(dbgWriteAck), 32'd1);
        tick();
        idle();
        pReadReg1 = 5'd5; pReadReg2 = 5'd6;
        settle();
        chk("r5_readback", pReadData1, 32'h12345678);
        chk("r6_readback", pReadData2, 32'hDEADBEEF);
        tick();

        // Writes requested while reset is low must not land.
        reset = 1'b0;
        pRegWrite = 1'b1; pWriteReg = 5'd9; pWriteData = ~model[9];
        settle();
        chk("rst_gate_ack", 32'(dbgWriteAck), 32'd0);
        tick();
        reset = 1'b1;
        idle();
        pReadReg1 = 5'd9;
        settle();
        chk("rst_no_write", pReadData1, model[9]);
        tick();

        pRegWrite = 1'b1; pWriteReg = 5'd1; pWriteData = 32'hAAAAAAAA; tick();
        pWriteReg = 5'd2; pWriteData = 32'h55555555; tick();
        idle();
        do_dump(100, -1, 1'b0, -1, 1'b0);
        do_dump(100, 7, 1'b0, -1, 1'b0);
        do_dump(70, -1, 1'b1, -1, 1'b0);
        do_dump(60, -1, 1'b0, -1, 1'b1);
        do_dump(100, -1, 1'b0, 10, 1'b0);
        do_dump(100, -1, 1'b0, -1, 1'b0);
        do_dump(40, -1, 1'b0, -1, 1'b1);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
